// File: rtl/std_cache_pkg.sv
// std_cache_pkg: shared dcache types, default geometry and the scrubber state encoding
package std_cache_pkg;
   localparam int DCACHE_NUM_WORDS = 256;
   localparam int DCACHE_SET_ASSOC = 8;
   typedef enum logic [1:0] {IDLE, RD, CHK, WB} scrub_state_e;
   function automatic int idx_width(input int n);
      return n > 1 ? $clog2(n) : 1;
   endfunction
   localparam int SetIdxWidth = idx_width(DCACHE_NUM_WORDS);
   localparam int WayIdxWidth = idx_width(DCACHE_SET_ASSOC);
endpackage

// File: rtl/dcache_scrub_ptr.sv
// dcache_scrub_ptr: (set, way) walk pointer with end-of-sweep pulse
module dcache_scrub_ptr import std_cache_pkg::*; #(
   parameter int NumSets = DCACHE_NUM_WORDS,
   parameter int NumWays = DCACHE_SET_ASSOC,
   localparam int SetW = idx_width(NumSets),
   localparam int WayW = idx_width(NumWays)
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            advance,
   output logic [SetW-1:0] set_idx,
   output logic [WayW-1:0] way_idx,
   output logic            sweep_done
);
   logic last_way, last;
   assign last_way = way_idx == WayW'(NumWays - 1);
   assign last = last_way && set_idx == SetW'(NumSets - 1);
   // way-major walk; the set steps when the way wraps, and both wrap on the final entry
   always_ff @(posedge clk) begin
      if (rst) begin
         set_idx <= '0;
         way_idx <= '0;
         sweep_done <= 1'b0;
      end else begin
         sweep_done <= advance && last;
         if (advance) begin
            way_idx <= last_way ? '0 : way_idx + 1'b1;
            if (last_way) set_idx <= last ? '0 : set_idx + 1'b1;
         end
      end
   end
endmodule

// File: rtl/dcache_scrub_ctrl.sv
// dcache_scrub_ctrl: background ECC scrubber on the lowest-priority tag-compare arbiter port
module dcache_scrub_ctrl import std_cache_pkg::*; #(
   parameter int NumSets = DCACHE_NUM_WORDS,
   parameter int NumWays = DCACHE_SET_ASSOC,
   parameter int LineWidth = 128,
   parameter int IntervalWidth = 16,
   parameter int CntWidth = 16,
   localparam int SetW = idx_width(NumSets),
   localparam int WayW = idx_width(NumWays)
) (
   input  logic                     clk_i,
   input  logic                     rst_i,
   input  logic                     enable_i,
   input  logic                     flush_i,
   input  logic [IntervalWidth-1:0] interval_i,
   output logic [NumWays-1:0]       req_o,
   output logic [SetW-1:0]          index_o,
   output logic                     we_o,
   output logic [LineWidth-1:0]     wdata_o,
   input  logic                     gnt_i,
   input  logic [LineWidth-1:0]     rdata_i,
   input  logic                     corr_err_i,
   input  logic                     uncorr_err_i,
   input  logic                     snoop_we_i,
   input  logic [SetW-1:0]          snoop_index_i,
   output logic                     busy_o,
   output logic                     uncorr_o,
   output logic [SetW-1:0]          uncorr_index_o,
   output logic [WayW-1:0]          uncorr_way_o,
   output logic                     sweep_done_o,
   output logic [CntWidth-1:0]      corr_cnt_o,
   output logic [CntWidth-1:0]      uncorr_cnt_o
);
   scrub_state_e state;
   logic [IntervalWidth-1:0] timer;
   logic [SetW-1:0] set_ptr;
   logic [WayW-1:0] way_ptr;
   logic [NumWays-1:0] way_oh;
   logic go, hit, adv;
   assign go = enable_i && !flush_i;
   // another requester wrote our set while we hold its data: the read is stale, retry the entry
   assign hit = snoop_we_i && snoop_index_i == set_ptr && (state == CHK || state == WB);
   assign adv = !hit && ((state == CHK && (uncorr_err_i || !corr_err_i)) || (state == WB && go && gnt_i));
   assign way_oh = NumWays'(1) << way_ptr;
   assign busy_o = state != IDLE;
   dcache_scrub_ptr #(.NumSets(NumSets), .NumWays(NumWays)) u_ptr (
      .clk(clk_i),
      .rst(rst_i),
      .advance(adv),
      .set_idx(set_ptr),
      .way_idx(way_ptr),
      .sweep_done(sweep_done_o)
   );
   // scrub FSM with registered request, write-back line, error reporting and saturating counters
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state <= IDLE;
         timer <= interval_i;
         req_o <= '0;
         index_o <= '0;
         we_o <= 1'b0;
         wdata_o <= '0;
         uncorr_o <= 1'b0;
         uncorr_index_o <= '0;
         uncorr_way_o <= '0;
         corr_cnt_o <= '0;
         uncorr_cnt_o <= '0;
      end else begin
         uncorr_o <= 1'b0;
         case (state)
            IDLE: if (go) begin
               if (timer == '0) begin
                  state <= RD;
                  req_o <= way_oh;
                  index_o <= set_ptr;
               end else timer <= timer - 1'b1;
            end
            RD: if (!go || gnt_i) begin
               state <= go ? CHK : IDLE;
               req_o <= '0;
               timer <= interval_i;
            end
            CHK: begin
               wdata_o <= rdata_i;
               if (!hit && !uncorr_err_i && corr_err_i) begin
                  state <= WB;
                  req_o <= way_oh;
                  we_o <= 1'b1;
                  if (~&corr_cnt_o) corr_cnt_o <= corr_cnt_o + 1'b1;
               end else begin
                  state <= IDLE;
                  timer <= interval_i;
                  if (!hit && uncorr_err_i) begin
                     uncorr_o <= 1'b1;
                     uncorr_index_o <= set_ptr;
                     uncorr_way_o <= way_ptr;
                     if (~&uncorr_cnt_o) uncorr_cnt_o <= uncorr_cnt_o + 1'b1;
                  end
               end
            end
            WB: if (!go || hit || gnt_i) begin
               state <= IDLE;
               req_o <= '0;
               we_o <= 1'b0;
               timer <= interval_i;
            end
            default: state <= IDLE;
         endcase
      end
   end
endmodule

// File: tb/tb_dcache_scrub_ctrl.sv
// tb_dcache_scrub_ctrl: transaction-level scoreboard acting as arbiter and SRAM for the scrubber
module tb_dcache_scrub_ctrl;
   localparam int NS = 4, NW = 2, LW = 128, IW = 4, CW = 2, TOT = NS * NW;
   logic clk_i = 1'b0;
   logic rst_i, enable_i, flush_i, gnt_i, corr_err_i, uncorr_err_i, snoop_we_i;
   logic we_o, busy_o, uncorr_o, sweep_done_o;
   logic [IW-1:0] interval_i;
   logic [NW-1:0] req_o;
   logic [1:0] index_o, snoop_index_i, uncorr_index_o;
   logic [0:0] uncorr_way_o;
   logic [LW-1:0] wdata_o, rdata_i, a5;
   logic [CW-1:0] corr_cnt_o, uncorr_cnt_o;
   int checks = 0, errors = 0;
   int ent, corr_m, unc_m, exp_unc_ent, cyc, n_unc, force_ent, force_kind, snoop_ent, e0;
   int gnt_pct, err_pct, snp_pct, flush_pct;
   bit chk, pend_wb, exp_unc, exp_sweep, all_corr, snoop_force;
   logic [LW-1:0] exp_line;
   int rd_log[$], wr_log[$], sweep_cyc[$];
   logic [LW-1:0] wd_log[$];

   always #5 clk_i = ~clk_i;

   dcache_scrub_ctrl #(.NumSets(NS), .NumWays(NW), .LineWidth(LW), .IntervalWidth(IW), .CntWidth(CW)) dut (
      .clk_i(clk_i), .rst_i(rst_i), .enable_i(enable_i), .flush_i(flush_i), .interval_i(interval_i),
      .req_o(req_o), .index_o(index_o), .we_o(we_o), .wdata_o(wdata_o), .gnt_i(gnt_i),
      .rdata_i(rdata_i), .corr_err_i(corr_err_i), .uncorr_err_i(uncorr_err_i),
      .snoop_we_i(snoop_we_i), .snoop_index_i(snoop_index_i), .busy_o(busy_o), .uncorr_o(uncorr_o),
      .uncorr_index_o(uncorr_index_o), .uncorr_way_o(uncorr_way_o), .sweep_done_o(sweep_done_o),
      .corr_cnt_o(corr_cnt_o), .uncorr_cnt_o(uncorr_cnt_o)
   );

   function automatic int sat(input int v);
      return v > (1 << CW) - 1 ? (1 << CW) - 1 : v;
   endfunction

   function automatic int enc(input int e);
      return int'({2'(e / NW), NW'(1 << (e % NW))});
   endfunction

   function automatic logic [142:0] outs();
      return {req_o, we_o, index_o, wdata_o, busy_o, uncorr_o, uncorr_index_o, uncorr_way_o,
              sweep_done_o, corr_cnt_o, uncorr_cnt_o};
   endfunction

   task automatic advance();
      exp_sweep = ent == TOT - 1;
      ent = (ent + 1) % TOT;
   endtask

   task automatic do_reset();
      rst_i = 1'b1; enable_i = 1'b1; flush_i = 1'b0; gnt_i = 1'b0; corr_err_i = 1'b0;
      uncorr_err_i = 1'b0; snoop_we_i = 1'b0; snoop_index_i = '0; rdata_i = '0;
      repeat (2) @(negedge clk_i);
      rst_i = 1'b0;
      ent = 0; corr_m = 0; unc_m = 0; chk = 0; pend_wb = 0; exp_unc = 0; exp_sweep = 0;
      force_kind = 0; force_ent = -1; snoop_force = 0; all_corr = 0;
   endtask

   // one clock: check registered outputs, then play arbiter/SRAM for this cycle
   task automatic step();
      int kind;
      bit hit;
      cyc++;
      checks++;
      if (uncorr_o !== exp_unc || sweep_done_o !== exp_sweep) begin
         errors++;
         $display("FAIL pulses cyc %0d: uncorr_o=%b sweep_done_o=%b expected %b %b", cyc, uncorr_o, sweep_done_o, exp_unc, exp_sweep);
      end
      if (exp_unc) begin
         checks++;
         if (uncorr_index_o !== 2'(exp_unc_ent / NW) || uncorr_way_o !== 1'(exp_unc_ent % NW)) begin
            errors++;
            $display("FAIL uncorr_loc: set=%0d way=%0d expected %0d %0d", uncorr_index_o, uncorr_way_o, exp_unc_ent / NW, exp_unc_ent % NW);
         end
      end
      checks++;
      if (corr_cnt_o !== CW'(corr_m) || uncorr_cnt_o !== CW'(unc_m)) begin
         errors++;
         $display("FAIL counters cyc %0d: corr=%0d uncorr=%0d expected %0d %0d", cyc, corr_cnt_o, uncorr_cnt_o, corr_m, unc_m);
      end
      if (sweep_done_o === 1'b1) sweep_cyc.push_back(cyc);
      if (uncorr_o === 1'b1) n_unc++;
      exp_unc = 0;
      exp_sweep = 0;
      gnt_i = 1'b0; corr_err_i = 1'b0; uncorr_err_i = 1'b0;
      rdata_i = {$urandom, $urandom, $urandom, $urandom};
      flush_i = int'($urandom_range(99)) < flush_pct;
      snoop_we_i = int'($urandom_range(99)) < snp_pct;
      snoop_index_i = 2'($urandom_range(NS - 1));
      if (chk) begin
         checks++;
         if (req_o !== '0 || busy_o !== 1'b1) begin
            errors++;
            $display("FAIL chk_state: req_o=%b busy_o=%b expected 0 1", req_o, busy_o);
         end
         chk = 0;
         kind = int'($urandom_range(99)) < err_pct ? int'($urandom_range(1, 3)) : 0;
         if (all_corr) kind = 1;
         if (ent == force_ent && force_kind != 0) begin
            kind = force_kind;
            force_kind = 0;
            rdata_i = a5;
         end
         corr_err_i = kind[0];
         uncorr_err_i = kind[1];
         hit = snoop_we_i && int'(snoop_index_i) == ent / NW;
         if (!hit) begin
            if (kind[1]) begin
               unc_m = sat(unc_m + 1);
               exp_unc = 1;
               exp_unc_ent = ent;
               advance();
            end else if (kind[0]) begin
               corr_m = sat(corr_m + 1);
               pend_wb = 1;
               exp_line = rdata_i;
            end else advance();
         end
      end else if (req_o !== '0) begin
         checks++;
         if (req_o !== NW'(1 << (ent % NW)) || index_o !== 2'(ent / NW) || we_o !== pend_wb || busy_o !== 1'b1 ||
             (pend_wb && wdata_o !== exp_line)) begin
            errors++;
            $display("FAIL request cyc %0d: req=%b idx=%0d we=%b busy=%b wdata=%h expected req=%b idx=%0d we=%b wdata=%h",
                     cyc, req_o, index_o, we_o, busy_o, wdata_o, NW'(1 << (ent % NW)), ent / NW, pend_wb, exp_line);
         end
         if (snoop_force && pend_wb && ent == snoop_ent) begin
            snoop_we_i = 1'b1;
            snoop_index_i = 2'(ent / NW);
            snoop_force = 0;
         end
         hit = snoop_we_i && int'(snoop_index_i) == ent / NW;
         if (flush_i) pend_wb = 0;
         else begin
            gnt_i = int'($urandom_range(99)) < gnt_pct;
            if (pend_wb && hit) pend_wb = 0;
            else if (pend_wb && gnt_i) begin
               pend_wb = 0;
               wr_log.push_back(ent);
               wd_log.push_back(wdata_o);
               advance();
            end else if (gnt_i) begin
               chk = 1;
               rd_log.push_back(int'({index_o, req_o}));
            end
         end
      end else begin
         checks++;
         if (pend_wb || we_o !== 1'b0) begin
            errors++;
            $display("FAIL idle cyc %0d: req=%b we=%b expected write-back pending=%b", cyc, req_o, we_o, pend_wb);
         end
      end
      @(negedge clk_i);
   endtask

   task automatic test_reset();
      interval_i = '0;
      do_reset();
      checks++;
      if (outs() !== '0) begin
         errors++;
         $display("FAIL reset_state: outputs=%h expected 0", outs());
      end
   endtask

   task automatic test_sweep();
      gnt_pct = 100; err_pct = 0; snp_pct = 0; flush_pct = 0;
      rd_log.delete();
      sweep_cyc.delete();
      repeat (60) step();
      checks++;
      if (sweep_cyc.size() < 2 || sweep_cyc[1] - sweep_cyc[0] != 3 * TOT) begin
         errors++;
         $display("FAIL sweep_period: pulses=%0d gap=%0d expected gap %0d", sweep_cyc.size(),
                  sweep_cyc.size() < 2 ? -1 : sweep_cyc[1] - sweep_cyc[0], 3 * TOT);
      end
      for (int i = 0; i < TOT; i++) begin
         checks++;
         if (rd_log.size() <= i || rd_log[i] != enc(i)) begin
            errors++;
            $display("FAIL walk_order %0d: got %h expected %h", i, rd_log.size() <= i ? -1 : rd_log[i], enc(i));
         end
      end
   endtask

   task automatic test_corr();
      do_reset();
      force_ent = 5; force_kind = 1;
      wr_log.delete(); wd_log.delete();
      for (int i = 0; i < 100 && (force_kind != 0 || pend_wb || chk); i++) step();
      checks++;
      if (wr_log.size() != 1 || wr_log[0] != 5 || wd_log[0] !== a5) begin
         errors++;
         $display("FAIL corr_wb: writes=%0d ent=%0d data=%h expected 1 5 %h", wr_log.size(),
                  wr_log.size() ? wr_log[0] : -1, wd_log.size() ? wd_log[0] : '0, a5);
      end
      checks++;
      if (corr_cnt_o !== 2'd1) begin
         errors++;
         $display("FAIL corr_cnt: got %0d expected 1", corr_cnt_o);
      end
   endtask

   task automatic test_uncorr();
      force_ent = 6; force_kind = 3; n_unc = 0;
      wr_log.delete();
      for (int i = 0; i < 100 && (force_kind != 0 || chk || exp_unc); i++) step();
      checks++;
      if (n_unc != 1 || uncorr_index_o !== 2'd3 || uncorr_way_o !== 1'b0 || uncorr_cnt_o !== 2'd1 || wr_log.size() != 0) begin
         errors++;
         $display("FAIL uncorr: pulses=%0d set=%0d way=%0d cnt=%0d writes=%0d expected 1 3 0 1 0",
                  n_unc, uncorr_index_o, uncorr_way_o, uncorr_cnt_o, wr_log.size());
      end
   endtask

   task automatic test_snoop();
      int reads;
      force_ent = 7; force_kind = 1; snoop_force = 1; snoop_ent = 7;
      rd_log.delete(); wr_log.delete();
      for (int i = 0; i < 100 && (force_kind != 0 || pend_wb || chk || ent == 7); i++) step();
      reads = 0;
      foreach (rd_log[i]) if (rd_log[i] == enc(7)) reads++;
      checks++;
      if (wr_log.size() != 0 || reads != 2 || corr_cnt_o !== 2'd2) begin
         errors++;
         $display("FAIL snoop_cancel: writes=%0d rereads=%0d corr=%0d expected 0 2 2", wr_log.size(), reads, corr_cnt_o);
      end
   endtask

   task automatic test_flush();
      gnt_pct = 0;
      for (int i = 0; i < 20 && req_o === '0; i++) step();
      repeat (10) step();
      e0 = ent;
      flush_pct = 100;
      step();
      checks++;
      if (req_o !== '0 || ent != e0) begin
         errors++;
         $display("FAIL flush_drop: req_o=%b entry=%0d expected 0 %0d", req_o, ent, e0);
      end
      repeat (3) step();
      flush_pct = 0; gnt_pct = 100;
      rd_log.delete();
      for (int i = 0; i < 20 && rd_log.size() == 0; i++) step();
      checks++;
      if (rd_log.size() == 0 || rd_log[0] != enc(e0)) begin
         errors++;
         $display("FAIL flush_retry: got %h expected %h", rd_log.size() ? rd_log[0] : -1, enc(e0));
      end
   endtask

   task automatic test_sat_and_reset();
      interval_i = '0;
      do_reset();
      all_corr = 1; gnt_pct = 100;
      wr_log.delete();
      for (int i = 0; i < 200 && wr_log.size() < 5; i++) step();
      checks++;
      if (wr_log.size() != 5 || corr_cnt_o !== 2'b11) begin
         errors++;
         $display("FAIL corr_saturate: writes=%0d corr=%0d expected 5 3", wr_log.size(), corr_cnt_o);
      end
      for (int i = 0; i < 20 && !(req_o !== '0 && we_o === 1'b1); i++) step();
      rst_i = 1'b1;
      @(negedge clk_i);
      checks++;
      if (outs() !== '0) begin
         errors++;
         $display("FAIL reset_mid_wb: outputs=%h expected 0", outs());
      end
      do_reset();
   endtask

   task automatic test_random();
      interval_i = IW'($urandom_range(3));
      do_reset();
      gnt_pct = 60; err_pct = 25; snp_pct = 15; flush_pct = 5;
      rd_log.delete();
      repeat (3000) step();
      checks++;
      if (rd_log.size() < 100) begin
         errors++;
         $display("FAIL random_progress: reads=%0d expected at least 100", rd_log.size());
      end
   endtask

   initial begin
      a5 = {16{8'hA5}};
      cyc = 0;
      gnt_pct = 0; err_pct = 0; snp_pct = 0; flush_pct = 0;
      test_reset();
      test_sweep();
      test_corr();
      test_uncorr();
      test_snoop();
      test_flush();
      test_sat_and_reset();
      test_random();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
